// File: rtl/cmp_result_tally_if.sv
// Result-line bundle between the 2-bit comparator, its driver and the tally monitor.
// Latency: none, wires only.
// Backpressure: none; the monitor accepts a sample whenever in_valid is high in RUN.
interface cmp_result_tally_if #(
  parameter int CNT_W = 8
);
  logic             start;
  logic             in_valid;
  logic             F1;
  logic             F2;
  logic             F3;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] gt_cnt;
  logic [CNT_W-1:0] eq_cnt;
  logic [CNT_W-1:0] lt_cnt;
  logic [CNT_W-1:0] err_cnt;
  logic [CNT_W-1:0] streak;
  logic             alarm;

  modport master (
    output start, in_valid, F1, F2, F3,
    input  busy, done, gt_cnt, eq_cnt, lt_cnt, err_cnt, streak, alarm
  );

  modport slave (
    input  start, in_valid, F1, F2, F3,
    output busy, done, gt_cnt, eq_cnt, lt_cnt, err_cnt, streak, alarm
  );
endinterface

// File: rtl/cmp_result_tally.sv
// Tallies comparator results (gt/eq/lt/malformed) over a window, tracks run length, raises a sticky alarm.
// Latency: one cycle; a sample accepted at an edge is visible right after it, and done follows the last sample.
// Backpressure: none; every in_valid cycle in RUN is consumed, and inputs are ignored in IDLE and DONE.
module cmp_result_tally #(
  parameter int CNT_W     = 8,
  parameter int WINDOW    = 16,
  parameter int STREAK_TH = 4
) (
  input logic               clk,
  input logic               rst_n,
  cmp_result_tally_if.slave bus
);
  localparam int IDX_W = $clog2(WINDOW + 1);
  localparam logic [CNT_W-1:0] TH       = CNT_W'(STREAK_TH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WINDOW - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  typedef enum logic [1:0] {K_NONE, K_GT, K_EQ, K_LT} kind_t;

  state_t           state;
  kind_t            kind;
  kind_t            prev_kind;
  logic [IDX_W-1:0] idx;
  logic [CNT_W-1:0] gt_q, eq_q, lt_q, err_q, streak_q;
  logic [CNT_W-1:0] streak_nxt;
  logic             busy_q, done_q, alarm_q;

  // Counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

  // Decode the result triple; anything not exactly one-hot is malformed.
  always_comb begin
    kind = K_NONE;
    case ({bus.F1, bus.F2, bus.F3})
      3'b100:  kind = K_GT;
      3'b010:  kind = K_EQ;
      3'b001:  kind = K_LT;
      default: kind = K_NONE;
    endcase
  end

  // Run length if this sample is well formed; prev_kind is K_NONE after an error so a new run starts at 1.
  always_comb begin
    streak_nxt = CNT_W'(1);
    if (kind == prev_kind) streak_nxt = sat_inc(streak_q);
  end

  // Window control FSM plus all tallies, with registered busy/done.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      prev_kind <= K_NONE;
      idx       <= '0;
      gt_q      <= '0;
      eq_q      <= '0;
      lt_q      <= '0;
      err_q     <= '0;
      streak_q  <= '0;
      alarm_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          if (bus.start) begin
            state     <= RUN;
            busy_q    <= 1'b1;
            prev_kind <= K_NONE;
            idx       <= '0;
            gt_q      <= '0;
            eq_q      <= '0;
            lt_q      <= '0;
            err_q     <= '0;
            streak_q  <= '0;
            alarm_q   <= 1'b0;
          end
        end
        RUN: begin
          if (bus.in_valid) begin
            if (kind != K_NONE) begin
              case (kind)
                K_GT:    gt_q <= sat_inc(gt_q);
                K_EQ:    eq_q <= sat_inc(eq_q);
                K_LT:    lt_q <= sat_inc(lt_q);
                default: ;
              endcase
              streak_q  <= streak_nxt;
              prev_kind <= kind;
              if (streak_nxt == TH) alarm_q <= 1'b1;
            end else begin
              err_q     <= sat_inc(err_q);
              streak_q  <= '0;
              prev_kind <= K_NONE;
            end
            idx <= idx + IDX_W'(1);
            if (idx == LAST_IDX) begin
              state  <= DONE;
              busy_q <= 1'b0;
              done_q <= 1'b1;
            end
          end
        end
        DONE: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.gt_cnt  = gt_q;
  assign bus.eq_cnt  = eq_q;
  assign bus.lt_cnt  = lt_q;
  assign bus.err_cnt = err_q;
  assign bus.streak  = streak_q;
  assign bus.alarm   = alarm_q;
endmodule

// File: doc/cmp_result_tally.md
Name: cmp_result_tally

Overview:
- Sequential monitor that sits directly downstream of the 2-bit magnitude comparator and consumes its three result lines, F1 (A>B), F2 (A==B) and F3 (A<B).
- Over a window of WINDOW valid samples it counts greater, equal, less and malformed results.
- It tracks the run length of identical results and raises a sticky alarm on a long run.
- It pulses done when the window completes, so a full 16-combination operand sweep can be checked in hardware.

Parameters:
- CNT_W, 8, width of all counters and of streak.
- WINDOW, 16, number of accepted samples per measurement window (16 = all 2-bit A/B combinations).
- STREAK_TH, 4, streak length at which alarm sets.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- start  in  1  begins a window; honoured only in IDLE.
- in_valid  in  1  the F1/F2/F3 triple is a sample this cycle.
- F1  in  1  comparator A>B.
- F2  in  1  comparator A==B.
- F3  in  1  comparator A<B.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse at window end.
- gt_cnt  out  CNT_W  count of one-hot F1 samples.
- eq_cnt  out  CNT_W  count of one-hot F2 samples.
- lt_cnt  out  CNT_W  count of one-hot F3 samples.
- err_cnt  out  CNT_W  count of samples whose {F1,F2,F3} is not exactly one-hot.
- streak  out  CNT_W  current run length of identical valid results.
- alarm  out  1  sticky long-run flag.

Behaviour:
- Reset: rst_n low at a clk edge forces state IDLE and all outputs and internal registers to 0. This applies in every state, including mid-RUN. No asynchronous path.
- States: IDLE, RUN, DONE.
- IDLE: busy=0, done=0; in_valid is ignored; counters hold their last values.
  - start=1 moves to RUN next cycle and, on that same edge, clears all counters, streak, alarm, the sample index and the previous-kind register.
- RUN: busy=1. Each cycle with in_valid=1 accepts one sample:
  - One-hot triple: increments the matching counter.
  - Any other triple (000, 011, 101, 110, 111): increments err_cnt.
  - Every accepted sample increments the sample index. in_valid=0 cycles change nothing.
- Streak rule:
  - A valid sample of the same kind as the previous valid sample sets streak to streak+1. Any other valid sample sets streak to 1.
  - An error sample sets streak to 0 and clears previous-kind, so the next valid sample starts at 1.
- alarm: set on the edge where the updated streak equals STREAK_TH, for any kind. It stays set until the next start or reset.
- Saturation: all counters and streak saturate at 2^CNT_W-1 and never wrap. The sample index is internal and unsaturated.
- Timing:
  - Outputs are registered; a sample accepted at edge k is visible after edge k.
  - The edge accepting sample number WINDOW also moves to DONE.
- DONE: one cycle, done=1, busy=0, then IDLE. in_valid and start are ignored in DONE. done is never high in any other state.
- start in RUN is ignored.
- Invariant: at done, gt_cnt+eq_cnt+lt_cnt+err_cnt = WINDOW when WINDOW <= 2^CNT_W-1.

Test Plan:
- Reset/idle: rst_n low 2 cycles, then 5 in_valid pulses without start -> all outputs 0, busy 0, done never pulses.
- Full sweep: start, then 16 consecutive valid samples, with A={A1,A0} as the outer loop 0..3 and B={B1,B0} as the inner loop 0..3 and F1/F2/F3 set to the true comparison -> done exactly one cycle after the 16th sample; gt=6, eq=4, lt=6, err=0, max streak 3, alarm=0.
- Malformed inputs: start, then samples 010, 000, 010, 110 with idle gaps between -> err_cnt=2, eq_cnt=2, streak=0 after the final sample, no done.
- Alarm: start, then 4 lt samples (001) separated by in_valid=0 gaps -> streak=4 and alarm=1 after the 4th. A following gt sample gives streak=1 with alarm still 1; the next start clears it.
- Saturation: CNT_W=3, WINDOW=10, 10 eq samples -> eq_cnt=7, streak=7, alarm=1, done after the 10th sample.
- Reset mid-run: start, 5 valid samples, a start pulse in RUN (ignored, counts continue), then rst_n low one cycle -> all outputs 0, busy 0, state IDLE.
